ir_beacon_decoder: RTL

IR_BEACON_DECODER -- requirements
Module: ir_beacon_decoder

---
 rtl/ir_beacon_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ir_beacon_decoder.sv
// IR beacon decoder: measures rising-edge periods of a synchronized IR input and locks onto 1 kHz or 10 kHz beacons.
// Optional input glitch filter is enabled by defining IR_GLITCH_FILTER_EN.
module ir_beacon_decoder #(
    parameter int unsigned P1K_MIN  = 90_000,
    parameter int unsigned P1K_MAX  = 110_000,
    parameter int unsigned P10K_MIN = 9_000,
    parameter int unsigned P10K_MAX = 11_000,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IR_In,
    output logic        IR_1k,
    output logic        IR_10k,
    output logic [17:0] Period,
    output logic        Sig_Lost
);

    typedef enum logic [2:0] {
        NO_SIG,
        CAND_1K,
        CAND_10K,
        LOCK_1K,
        LOCK_10K
    } state_t;

    localparam logic [17:0] TIMEOUT_C = 18'(TIMEOUT);
    localparam logic [2:0]  LOCK_C    = 3'(LOCK_CNT);

    logic        sync1_q, sync2_q;
    logic        sigLevel, sigPrev_q, riseEdge;
    logic [17:0] cnt_q, cnt_d, period_q, period_d;
    logic        startPend_q, startPend_d;
    logic [2:0]  match_q, match_d;
    state_t      state_q, state_d;
    logic        ir1k_q, ir10k_q, lost_q, lost_d;
    logic        isA, isB, classify, timeoutHit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= IR_In;
            sync2_q <= sync1_q;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [2:0] filtCnt_q, filtCnt_d;

    // Level follows the input only after 8 consecutive samples that disagree with it.
    always_comb begin
        filt_d    = filt_q;
        filtCnt_d = 3'd0;
        if (sync2_q != filt_q) begin
            if (filtCnt_q == 3'd7) begin
                filt_d = sync2_q;
            end else begin
                filtCnt_d = filtCnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q    <= 1'b0;
            filtCnt_q <= 3'd0;
        end else begin
            filt_q    <= filt_d;
            filtCnt_q <= filtCnt_d;
        end
    end

    assign sigLevel = filt_q;
`else
    assign sigLevel = sync2_q;
`endif

    assign riseEdge   = sigLevel & ~sigPrev_q;
    assign classify   = riseEdge & ~startPend_q;
    assign isA        = (cnt_q >= 18'(P1K_MIN)) && (cnt_q <= 18'(P1K_MAX));
    assign isB        = (cnt_q >= 18'(P10K_MIN)) && (cnt_q <= 18'(P10K_MAX));
    // An edge landing on the saturated count wins; the start-pending flag keeps the timeout one-shot.
    assign timeoutHit = (cnt_q == TIMEOUT_C) && !riseEdge && !startPend_q;

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        period_d    = period_q;
        startPend_d = startPend_q;
        lost_d      = 1'b0;
        cnt_d       = cnt_q;

        if (riseEdge) begin
            cnt_d       = 18'd1;
            startPend_d = 1'b0;
        end else if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + 18'd1;
        end

        if (classify) begin
            period_d = cnt_q;
            case (state_q)
                NO_SIG: begin
                    if (isA) begin
                        state_d = CAND_1K;
                        match_d = 3'd1;
                    end else if (isB) begin
                        state_d = CAND_10K;
                        match_d = 3'd1;
                    end
                end
                CAND_1K, CAND_10K: begin
                    if ((state_q == CAND_1K) ? isA : isB) begin
                        if (match_q + 3'd1 == LOCK_C) begin
                            state_d = (state_q == CAND_1K) ? LOCK_1K : LOCK_10K;
                            match_d = 3'd0;
                        end else begin
                            match_d = match_q + 3'd1;
                        end
                    end else if (isA) begin
                        state_d = CAND_1K;
                        match_d = 3'd1;
                    end else if (isB) begin
                        state_d = CAND_10K;
                        match_d = 3'd1;
                    end else begin
                        state_d = NO_SIG;
                        match_d = 3'd0;
                    end
                end
                LOCK_1K, LOCK_10K: begin
                    if ((state_q == LOCK_1K) ? isA : isB) begin
                        match_d = 3'd0;
                    end else if (match_q + 3'd1 == LOCK_C) begin
                        state_d = NO_SIG;
                        match_d = 3'd0;
                    end else begin
                        match_d = match_q + 3'd1;
                    end
                end
                default: begin
                    state_d = NO_SIG;
                    match_d = 3'd0;
                end
            endcase
        end else if (timeoutHit) begin
            state_d     = NO_SIG;
            match_d     = 3'd0;
            startPend_d = 1'b1;
            lost_d      = (state_q == LOCK_1K) || (state_q == LOCK_10K);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NO_SIG;
            match_q     <= 3'd0;
            cnt_q       <= 18'd0;
            period_q    <= 18'd0;
            startPend_q <= 1'b1;
            sigPrev_q   <= 1'b0;
            ir1k_q      <= 1'b0;
            ir10k_q     <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            startPend_q <= startPend_d;
            sigPrev_q   <= sigLevel;
            ir1k_q      <= (state_d == LOCK_1K);
            ir10k_q     <= (state_d == LOCK_10K);
            lost_q      <= lost_d;
        end
    end

    assign IR_1k    = ir1k_q;
    assign IR_10k   = ir10k_q;
    assign Period   = period_q;
    assign Sig_Lost = lost_q;

endmodule
